// File: rtl/mem_controller.sv
// Byte-serial RAM controller that sits below the cache.
// It accepts one instruction fetch or one data load/store at a time.
// Each access is split into byte transfers on the 8-bit RAM bus.
// Load results are assembled little-endian and then sign- or zero-extended.
// A pipeline clear aborts a fetch or load that is in flight. A store always completes.
module mem_controller #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_done,
    output logic [31:0] inst_data,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [2:0]  data_type,
    output logic        data_done,
    output logic [31:0] data_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        IO_WAIT = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [2:0]  len_r;
    logic [2:0]  type_r;
    logic        is_inst_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] buf_r;
    logic        mem_wr_r;

    logic [2:0]  cnt_next_s;
    logic [31:0] rd_buf_s;
    logic        io_s;
    logic        busy_done_s;

    // Transfer length in bytes for a size code; 10 and 11 both mean a word.
    function automatic logic [2:0] len_of(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Select byte lane idx of a word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Replace byte lane idx of a word with b.
    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Sign- or zero-extend an assembled load according to its type.
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] typ);
        logic [31:0] r;
        case (typ[1:0])
            2'b00:   r = typ[2] ? {{24{raw[7]}}, raw[7:0]} : {24'h00_0000, raw[7:0]};
            2'b01:   r = typ[2] ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Next byte index, read buffer with the incoming byte merged, I/O decode, done-cycle block.
    always_comb begin
        cnt_next_s  = cnt_r + 3'd1;
        rd_buf_s    = put_lane(buf_r, cnt_r[1:0], mem_din);
        io_s        = (addr_r >= IO_BASE);
        busy_done_s = inst_done | data_done;
    end

    // While the controller is stalled, the write strobe is held low.
    assign mem_wr = mem_wr_r & rdy_in;

    // Main access sequencer: accept, serialize bytes, assemble and report completion.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            len_r      <= 3'd0;
            type_r     <= 3'd0;
            is_inst_r  <= 1'b0;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            buf_r      <= 32'h0000_0000;
            mem_wr_r   <= 1'b0;
            mem_a      <= 32'h0000_0000;
            mem_dout   <= 8'h00;
            inst_done  <= 1'b0;
            inst_data  <= 32'h0000_0000;
            data_done  <= 1'b0;
            data_rdata <= 32'h0000_0000;
        end else if (rdy_in) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    mem_wr_r <= 1'b0;
                    // Requests are not re-sampled while a done pulse is still showing.
                    if (busy_done_s) begin
                        state_r <= IDLE;
                    end else if (data_req && data_write) begin
                        addr_r    <= data_addr;
                        wdata_r   <= data_wdata;
                        type_r    <= data_type;
                        len_r     <= len_of(data_type[1:0]);
                        is_inst_r <= 1'b0;
                        buf_r     <= 32'h0000_0000;
                        if ((data_addr >= IO_BASE) && io_buffer_full) begin
                            cnt_r   <= 3'd0;
                            state_r <= IO_WAIT;
                        end else begin
                            mem_a    <= data_addr;
                            mem_dout <= data_wdata[7:0];
                            mem_wr_r <= 1'b1;
                            cnt_r    <= 3'd1;
                            state_r  <= WRITE;
                        end
                    end else if (data_req && !clear_in) begin
                        addr_r    <= data_addr;
                        type_r    <= data_type;
                        len_r     <= len_of(data_type[1:0]);
                        is_inst_r <= 1'b0;
                        buf_r     <= 32'h0000_0000;
                        mem_a     <= data_addr;
                        cnt_r     <= 3'd0;
                        state_r   <= READ;
                    end else if (inst_req && !clear_in) begin
                        addr_r    <= inst_addr;
                        type_r    <= 3'b010;
                        len_r     <= 3'd4;
                        is_inst_r <= 1'b1;
                        buf_r     <= 32'h0000_0000;
                        mem_a     <= inst_addr;
                        cnt_r     <= 3'd0;
                        state_r   <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    mem_wr_r <= 1'b0;
                    if (clear_in) begin
                        cnt_r   <= 3'd0;
                        state_r <= IDLE;
                    end else begin
                        buf_r <= rd_buf_s;
                        cnt_r <= cnt_next_s;
                        if (cnt_next_s == len_r) begin
                            if (is_inst_r) begin
                                inst_done <= 1'b1;
                                inst_data <= rd_buf_s;
                            end else begin
                                data_done  <= 1'b1;
                                data_rdata <= extend_load(rd_buf_s, type_r);
                            end
                            state_r <= IDLE;
                        end else begin
                            mem_a <= addr_r + {29'd0, cnt_next_s};
                        end
                    end
                end
                WRITE: begin
                    if (cnt_r == len_r) begin
                        mem_wr_r  <= 1'b0;
                        data_done <= 1'b1;
                        cnt_r     <= 3'd0;
                        state_r   <= IDLE;
                    end else if (io_s && io_buffer_full) begin
                        mem_wr_r <= 1'b0;
                        state_r  <= IO_WAIT;
                    end else begin
                        mem_a    <= addr_r + {29'd0, cnt_r};
                        mem_dout <= byte_of(wdata_r, cnt_r[1:0]);
                        mem_wr_r <= 1'b1;
                        cnt_r    <= cnt_next_s;
                    end
                end
                IO_WAIT: begin
                    if (io_buffer_full) begin
                        mem_wr_r <= 1'b0;
                    end else begin
                        mem_a    <= addr_r + {29'd0, cnt_r};
                        mem_dout <= byte_of(wdata_r, cnt_r[1:0]);
                        mem_wr_r <= 1'b1;
                        cnt_r    <= cnt_next_s;
                        state_r  <= WRITE;
                    end
                end
                default: begin
                    mem_wr_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed testbench for mem_controller.
// It uses a small byte RAM model that answers combinationally on the cycle after an address is issued.
module tb_mem_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_done;
    logic [31:0] inst_data;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [2:0]  data_type;
    logic        data_done;
    logic [31:0] data_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int checks = 0;
    int errors = 0;

    mem_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_data(inst_data),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_type(data_type), .data_done(data_done),
        .data_rdata(data_rdata), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk_in) begin
        if (mem_wr === 1'b1) ram[mem_a[9:0]] <= mem_dout;
    end

    task automatic test_reset();
        @(negedge clk_in);
        checks++;
        if ({inst_done, data_done, mem_wr, mem_a, mem_dout, inst_data, data_rdata} !== 107'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h dout=%h wr=%b id=%b dd=%b, want all zero",
                     mem_a, mem_dout, mem_wr, inst_done, data_done);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_fetch();
        int k;
        bit seen;
        @(negedge clk_in);
        inst_addr = 32'h0000_0100;
        inst_req  = 1'b1;
        @(posedge clk_in);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk_in); k++;
            if (inst_done === 1'b1) seen = 1'b1;
        end
        inst_req = 1'b0;
        checks++;
        if (!seen || k !== 5) begin
            errors++; $display("FAIL fetch_latency: got %0d cycles, want 5", k);
        end
        checks++;
        if (inst_data !== 32'h1234_5678) begin
            errors++; $display("FAIL fetch_data: got %h, want 12345678", inst_data);
        end
        @(negedge clk_in);
        checks++;
        if (inst_done !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse: inst_done=%b, want 0", inst_done);
        end
    endtask

    task automatic test_load();
        int k;
        bit seen;
        // signed byte at 0x20 = 0x80
        @(negedge clk_in);
        data_addr = 32'h20; data_type = 3'b100; data_write = 1'b0; data_req = 1'b1;
        @(posedge clk_in);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk_in); k++;
            if (data_done === 1'b1) seen = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (!seen || k !== 2) begin
            errors++; $display("FAIL lb_latency: got %0d cycles, want 2", k);
        end
        checks++;
        if (data_rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_signed: got %h, want ffffff80", data_rdata);
        end
        // unsigned half at 0x20 = 0x7F80
        @(negedge clk_in);
        data_type = 3'b001; data_req = 1'b1;
        @(posedge clk_in);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk_in); k++;
            if (data_done === 1'b1) seen = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (!seen || k !== 3) begin
            errors++; $display("FAIL lhu_latency: got %0d cycles, want 3", k);
        end
        checks++;
        if (data_rdata !== 32'h0000_7F80) begin
            errors++; $display("FAIL lhu_zero: got %h, want 00007f80", data_rdata);
        end
    endtask

    task automatic test_store();
        logic [31:0] w;
        logic [7:0]  eb;
        w = 32'hDEAD_BEEF;
        @(negedge clk_in);
        data_addr = 32'h40; data_type = 3'b010; data_write = 1'b1; data_wdata = w; data_req = 1'b1;
        @(posedge clk_in);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_in);
            if (k <= 4) begin
                eb = w[8*(k-1) +: 8];
                checks++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h40 + k - 1 || mem_dout !== eb) begin
                    errors++;
                    $display("FAIL sw_byte%0d: got wr=%b a=%h d=%h, want wr=1 a=%h d=%h",
                             k - 1, mem_wr, mem_a, mem_dout, 32'h40 + k - 1, eb);
                end
            end else begin
                checks++;
                if (data_done !== 1'b1 || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_done: got done=%b wr=%b, want done=1 wr=0", data_done, mem_wr);
                end
            end
        end
        data_req = 1'b0; data_write = 1'b0;
        checks++;
        if ({ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]} !== w) begin
            errors++;
            $display("FAIL sw_ram: got %h%h%h%h, want deadbeef", ram[12'h43], ram[12'h42],
                     ram[12'h41], ram[12'h40]);
        end
    endtask

    task automatic test_priority();
        int dk;
        int ik;
        int k;
        dk = 0; ik = 0; k = 0;
        @(negedge clk_in);
        inst_addr = 32'h100; inst_req = 1'b1;
        data_addr = 32'h40; data_type = 3'b010; data_write = 1'b0; data_req = 1'b1;
        @(posedge clk_in);
        while (ik == 0 && k < 40) begin
            @(negedge clk_in); k++;
            if (inst_done === 1'b1 && data_done === 1'b1) begin
                checks++; errors++;
                $display("FAIL prio_both_done: both done high at cycle %0d", k);
            end
            if (data_done === 1'b1 && dk == 0) begin
                dk = k; data_req = 1'b0;
                checks++;
                if (data_rdata !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL prio_data: got %h, want deadbeef", data_rdata);
                end
            end
            if (inst_done === 1'b1) begin
                ik = k; inst_req = 1'b0;
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
        checks++;
        if (dk !== 5) begin
            errors++; $display("FAIL prio_data_first: data_done at %0d, want 5", dk);
        end
        checks++;
        if (ik !== 11 || inst_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL prio_fetch_after: inst_done at %0d data %h, want 11 and 12345678",
                     ik, inst_data);
        end
    endtask

    task automatic test_clear();
        int k;
        bit seen;
        bit bad;
        // clear during a fetch aborts it
        @(negedge clk_in);
        inst_addr = 32'h100; inst_req = 1'b1;
        @(posedge clk_in);
        bad = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_in);
            if (inst_done === 1'b1) bad = 1'b1;
            if (j == 2) begin clear_in = 1'b1; inst_req = 1'b0; end
            if (j == 3) clear_in = 1'b0;
        end
        // controller must be idle now: a byte load is accepted right away
        data_addr = 32'h21; data_type = 3'b000; data_write = 1'b0; data_req = 1'b1;
        @(posedge clk_in);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk_in); k++;
            if (inst_done === 1'b1) bad = 1'b1;
            if (data_done === 1'b1) seen = 1'b1;
        end
        data_req = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL clear_fetch: inst_done=1 seen, want no inst_done");
        end
        checks++;
        if (!seen || k !== 2 || data_rdata !== 32'h0000_007F) begin
            errors++;
            $display("FAIL clear_idle: load after clear took %0d cycles data %h, want 2 and 0000007f",
                     k, data_rdata);
        end
        // clear during a store is ignored
        @(negedge clk_in);
        data_addr = 32'h50; data_type = 3'b001; data_write = 1'b1; data_wdata = 32'h0000_A55A;
        data_req = 1'b1;
        @(posedge clk_in);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk_in);
            if (j == 1) clear_in = 1'b1;
            if (j == 3) begin
                clear_in = 1'b0;
                checks++;
                if (data_done !== 1'b1) begin
                    errors++; $display("FAIL clear_store_done: data_done=%b, want 1", data_done);
                end
            end
        end
        data_req = 1'b0; data_write = 1'b0;
        checks++;
        if ({ram[12'h51], ram[12'h50]} !== 16'hA55A) begin
            errors++; $display("FAIL clear_store_ram: got %h%h, want a55a", ram[12'h51], ram[12'h50]);
        end
    endtask

    task automatic test_io_wait();
        int writes;
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        data_addr = 32'h0003_0000; data_type = 3'b000; data_write = 1'b1;
        data_wdata = 32'h0000_00C3; data_req = 1'b1;
        @(posedge clk_in);
        writes = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_in);
            if (mem_wr === 1'b1) writes++;
            if (k <= 3) begin
                checks++;
                if (mem_wr !== 1'b0) begin
                    errors++; $display("FAIL io_hold%0d: mem_wr=%b, want 0", k, mem_wr);
                end
            end
            if (k == 3) io_buffer_full = 1'b0;
            if (k == 4) begin
                checks++;
                if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'hC3) begin
                    errors++;
                    $display("FAIL io_write: got wr=%b a=%h d=%h, want wr=1 a=00030000 d=c3",
                             mem_wr, mem_a, mem_dout);
                end
            end
            if (k == 5) begin
                checks++;
                if (data_done !== 1'b1 || writes !== 1) begin
                    errors++;
                    $display("FAIL io_done: got done=%b writes=%0d, want done=1 writes=1",
                             data_done, writes);
                end
            end
        end
        data_req = 1'b0; data_write = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] w;
        bit          ewr;
        int          idx;
        w = 32'h1122_3344;
        @(negedge clk_in);
        data_addr = 32'h60; data_type = 3'b010; data_write = 1'b1; data_wdata = w; data_req = 1'b1;
        @(posedge clk_in);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            ewr = (k <= 6) && (k != 3) && (k != 4);
            idx = (k == 1) ? 0 : ((k <= 4) ? 1 : k - 3);
            checks++;
            if (k == 7) begin
                if (data_done !== 1'b1) begin
                    errors++; $display("FAIL stall_done: data_done=%b, want 1", data_done);
                end
            end else if (!ewr) begin
                if (mem_wr !== 1'b0) begin
                    errors++; $display("FAIL stall_gate%0d: mem_wr=%b, want 0", k, mem_wr);
                end
            end else if (mem_wr !== 1'b1 || mem_a !== 32'h60 + idx || mem_dout !== w[8*idx +: 8]) begin
                errors++;
                $display("FAIL stall_byte%0d: got wr=%b a=%h d=%h, want wr=1 a=%h d=%h",
                         k, mem_wr, mem_a, mem_dout, 32'h60 + idx, w[8*idx +: 8]);
            end
            if (k == 2) rdy_in = 1'b0;
            if (k == 4) rdy_in = 1'b1;
        end
        data_req = 1'b0; data_write = 1'b0;
        checks++;
        if ({ram[12'h63], ram[12'h62], ram[12'h61], ram[12'h60]} !== w) begin
            errors++;
            $display("FAIL stall_ram: got %h%h%h%h, want 11223344", ram[12'h63], ram[12'h62],
                     ram[12'h61], ram[12'h60]);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(negedge clk_in);
        inst_addr = 32'h100; inst_req = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0; inst_req = 1'b0;
        #1;
        checks++;
        if (mem_a !== 32'h0 || inst_done !== 1'b0) begin
            errors++; $display("FAIL reset_async: mem_a=%h inst_done=%b, want 0", mem_a, inst_done);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (inst_done === 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_abort: inst_done=1 seen after reset, want none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h020] = 8'h80; ram[12'h021] = 8'h7F;
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_write = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
        data_type = 3'b000;
        repeat (2) @(posedge clk_in);
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_priority();
        test_clear();
        test_io_wait();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
